// File: rtl/arbiter_pkg.sv
// ---------------------------------------------------------------------------
// arbiter_pkg: shared types, mode constants and helpers for arbiter_rr. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int ARB_MODE_RR    = 0;
  localparam int ARB_MODE_FIXED = 1;

  // OR-ing the indices of set bits yields the index when the input is one-hot.
  function automatic int unsigned onehot_to_idx(input logic [31:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (onehot[i]) idx = idx | 32'(i);
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// arbiter_rr_pick: combinational winner select, rotating priority from ptr. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arbiter_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  input  logic                 mode_i,
  output logic [NUM_PORTS-1:0] win_o,
  output logic                 any_o
);

  logic [IDX_W-1:0]       shift;
  logic [2*NUM_PORTS-1:0] req_dbl;
  logic [NUM_PORTS-1:0]   req_rot;
  logic [NUM_PORTS-1:0]   first_rot;
  logic [2*NUM_PORTS-1:0] win_dbl;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate back.
  assign shift     = mode_i ? '0 : ptr_i;
  assign req_dbl   = {req_i, req_i} >> shift;
  assign req_rot   = req_dbl[NUM_PORTS-1:0];
  assign first_rot = req_rot & (~req_rot + NUM_PORTS'(1));
  assign win_dbl   = {first_rot, first_rot} << shift;
  assign win_o     = win_dbl[2*NUM_PORTS-1:NUM_PORTS];
  assign any_o     = |req_i;

endmodule

`default_nettype wire

// File: rtl/arbiter_rr.sv
// ---------------------------------------------------------------------------
// arbiter_rr: registered arbiter with grant hold, release and hold timeout. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arbiter_rr
  import arbiter_pkg::*;
#(
  parameter int  NUM_PORTS = 4,
  parameter int  MAX_HOLD  = 8,
  parameter int  PRIO_MODE = ARB_MODE_RR,
  localparam int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 done_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic                 gnt_valid_o,
  output logic [IDX_W-1:0]     gnt_idx_o
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic                 valid_q, valid_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;

  logic [NUM_PORTS-1:0] win;
  logic                 any_req;
  logic                 owner_req;
  logic                 timeout;
  logic                 release_now;
  logic [IDX_W-1:0]     next_ptr;
  logic [IDX_W-1:0]     pick_ptr;
  logic [IDX_W-1:0]     win_idx;

  assign owner_req   = |(req_i & gnt_q);
  assign timeout     = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  assign release_now = (state_q == ARB_GRANT) && (done_i || !owner_req || timeout);
  assign next_ptr    = (idx_q == IDX_W'(NUM_PORTS - 1)) ? '0 : idx_q + IDX_W'(1);
  // Re-arbitration on release sees the already-advanced pointer.
  assign pick_ptr    = release_now ? next_ptr : ptr_q;
  assign win_idx     = IDX_W'(onehot_to_idx(32'(win)));

  arbiter_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req_i  (req_i),
    .ptr_i  (pick_ptr),
    .mode_i (PRIO_MODE == ARB_MODE_FIXED),
    .win_o  (win),
    .any_o  (any_req)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    if (state_q == ARB_GRANT && !release_now) hold_d = hold_q + HOLD_W'(1);
    if (release_now) ptr_d = next_ptr;
    if (state_q == ARB_IDLE || release_now) begin
      if (any_req) begin
        state_d = ARB_GRANT;
        gnt_d   = win;
        valid_d = 1'b1;
        idx_d   = win_idx;
        hold_d  = '0;
      end else begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = valid_q;
  assign gnt_idx_o   = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_arbiter_rr: directed and randomized checks of arbiter_rr in both modes. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_arbiter_rr;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         done = 1'b0;

  logic [N-1:0] gnt0, gnt1;
  logic         valid0, valid1;
  logic [1:0]   idx0, idx1;

  int checks = 0;
  int errors = 0;

  // Reference: owner index (-1 idle), pointer, cycles held including the current one.
  int m_owner[2];
  int m_ptr[2];
  int m_held[2];
  int m_idx[2];
  int m_maxhold[2] = '{4, 0};
  bit m_fixed[2]   = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  arbiter_rr #(.NUM_PORTS(N), .MAX_HOLD(4), .PRIO_MODE(0)) dut_rr (
    .clk_i(clk), .rst_i(rst), .req_i(req), .done_i(done),
    .gnt_o(gnt0), .gnt_valid_o(valid0), .gnt_idx_o(idx0)
  );

  arbiter_rr #(.NUM_PORTS(N), .MAX_HOLD(0), .PRIO_MODE(1)) dut_fx (
    .clk_i(clk), .rst_i(rst), .req_i(req), .done_i(done),
    .gnt_o(gnt1), .gnt_valid_o(valid1), .gnt_idx_o(idx1)
  );

  function automatic void model_update(int k);
    bit rearb;
    int start;
    if (rst) begin
      m_owner[k] = -1; m_ptr[k] = 0; m_held[k] = 0; m_idx[k] = 0;
      return;
    end
    rearb = (m_owner[k] < 0);
    if (m_owner[k] >= 0) begin
      if (done || !req[m_owner[k]] || (m_maxhold[k] != 0 && m_held[k] == m_maxhold[k])) begin
        m_ptr[k] = (m_owner[k] + 1) % N;
        rearb = 1'b1;
      end else begin
        m_held[k]++;
      end
    end
    if (rearb) begin
      start = m_fixed[k] ? 0 : m_ptr[k];
      m_owner[k] = -1;
      for (int i = 0; i < N; i++) begin
        if (m_owner[k] < 0 && req[(start + i) % N]) m_owner[k] = (start + i) % N;
      end
      if (m_owner[k] >= 0) begin
        m_held[k] = 1;
        m_idx[k]  = m_owner[k];
      end
    end
  endfunction

  function automatic logic [6:0] model_out(int k);
    logic [3:0] g;
    g = (m_owner[k] < 0) ? 4'b0000 : 4'(1 << m_owner[k]);
    return {g, m_owner[k] >= 0, 2'(m_idx[k])};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update(0);
    model_update(1);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({gnt0, valid0, idx0} !== 7'b0 || {gnt1, valid1, idx1} !== 7'b0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: rr=%b/%b/%0d fx=%b/%b/%0d required all zero",
                 c, gnt0, valid0, idx0, gnt1, valid1, idx1);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt0 !== 4'b0001 || valid0 !== 1'b1 || gnt1 !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant: rr=%b valid=%b fx=%b required 0001/1/0001", gnt0, valid0, gnt1);
    end
  endtask

  task automatic test_rr_done();
    logic [3:0] exp_g[3] = '{4'b0010, 4'b1000, 4'b0010};
    logic [1:0] exp_i[3] = '{2'd1, 2'd3, 2'd1};
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1010; done = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++;
      if (gnt0 !== exp_g[s] || idx0 !== exp_i[s] || valid0 !== 1'b1) begin
        errors++;
        $display("FAIL rr_done step %0d: gnt=%b idx=%0d valid=%b required %b idx %0d",
                 s, gnt0, idx0, valid0, exp_g[s], exp_i[s]);
      end
      done = 1'b1;
    end
    done = 1'b0;
  endtask

  task automatic test_timeout();
    logic [3:0] exp;
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0101; done = 1'b0;
    for (int c = 0; c < 9; c++) begin
      tick();
      exp = (c < 4 || c == 8) ? 4'b0001 : 4'b0100;
      checks++;
      if (gnt0 !== exp || valid0 !== 1'b1) begin
        errors++;
        $display("FAIL hold_timeout cycle %0d: gnt=%b valid=%b required %b/1", c, gnt0, valid0, exp);
      end
    end
  endtask

  task automatic test_sole_owner_drop();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0100; done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (gnt0 !== 4'b0100 || valid0 !== 1'b1) begin
        errors++;
        $display("FAIL sole_owner cycle %0d: gnt=%b valid=%b required 0100/1", c, gnt0, valid0);
      end
    end
    req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (gnt0 !== 4'b0000 || valid0 !== 1'b0 || idx0 !== 2'd2 || gnt1 !== 4'b0000 || valid1 !== 1'b0) begin
        errors++;
        $display("FAIL owner_drop cycle %0d: rr=%b/%b/%0d fx=%b/%b required 0000/0/2 and 0000/0",
                 c, gnt0, valid0, idx0, gnt1, valid1);
      end
    end
  endtask

  task automatic test_fixed();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111; done = 1'b0;
    tick();
    done = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (gnt1 !== 4'b0001 || idx1 !== 2'd0) begin
        errors++;
        $display("FAIL fixed_prio cycle %0d: gnt=%b idx=%0d required 0001 idx 0", c, gnt1, idx1);
      end
      tick();
    end
    req = 4'b1100;
    tick();
    done = 1'b0;
    req = 4'b1111;
    // Unlimited hold: the owner keeps the grant while others keep requesting.
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (gnt1 !== 4'b0100 || idx1 !== 2'd2 || valid1 !== 1'b1) begin
        errors++;
        $display("FAIL fixed_hold cycle %0d: gnt=%b idx=%0d valid=%b required 0100 idx 2", c, gnt1, idx1, valid1);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_grant();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0100; done = 1'b0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (gnt0 !== 4'b0100) begin
      errors++;
      $display("FAIL mid_grant_setup: gnt=%b required 0100", gnt0);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (gnt0 !== 4'b0000 || valid0 !== 1'b0 || idx0 !== 2'd0) begin
      errors++;
      $display("FAIL mid_grant_reset: gnt=%b valid=%b idx=%0d required 0000/0/0", gnt0, valid0, idx0);
    end
    rst = 1'b0;
    req = 4'b1001;
    tick();
    checks++;
    if (gnt0 !== 4'b0001 || idx0 !== 2'd0) begin
      errors++;
      $display("FAIL mid_grant_ptr: gnt=%b idx=%0d required 0001 idx 0", gnt0, idx0);
    end
  endtask

  task automatic test_random();
    logic [6:0] act;
    logic [6:0] exp;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 500; c++) begin
      req  = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
      done = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 49) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        act = (k == 0) ? {gnt0, valid0, idx0} : {gnt1, valid1, idx1};
        exp = model_out(k);
        checks++;
        if (act !== exp || !$onehot0(act[6:3])) begin
          errors++;
          $display("FAIL random dut%0d cycle %0d: gnt/valid/idx=%b/%b/%0d required %b/%b/%0d",
                   k, c, act[6:3], act[2], act[1:0], exp[6:3], exp[2], exp[1:0]);
        end
      end
    end
    rst = 1'b0; done = 1'b0; req = '0;
  endtask

  initial begin
    test_reset();
    test_rr_done();
    test_timeout();
    test_sole_owner_drop();
    test_fixed();
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arbiter_rr.md
Name: arbiter_rr

Overview:
- Parametrised, registered successor to the team's combinational fixed-priority arbiter.
- Arbitrates NUM_PORTS requesters onto one shared resource.
- Selectable policy: round-robin (default) or fixed lowest-index-first.
- A grant is held across cycles until released by the owner or by a hold-limit timeout.
- Sits in front of shared buses or memory ports where a transfer spans multiple cycles.

Parameters:
- NUM_PORTS, 4, number of requesters (>= 2).
- MAX_HOLD, 8, maximum consecutive cycles one grant may be held; 0 = unlimited.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority with index 0 highest.
- IDX_W, $clog2(NUM_PORTS), localparam, width of the grant index.

Ports:
- clk_i  input  1  single clock; all state updates on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- req_i  input  NUM_PORTS  per-port request level.
- done_i  input  1  owner releases the current grant this cycle.
- gnt_o  output  NUM_PORTS  registered one-hot grant; all-zero when idle.
- gnt_valid_o  output  1  high while any grant is held.
- gnt_idx_o  output  IDX_W  binary index of the granted port; holds its last value when idle.

Behaviour:
- Reset values: state IDLE; gnt_o=0; gnt_valid_o=0; gnt_idx_o=0; priority pointer ptr=0; hold counter=0.
- Reset has priority over every other event.
- States: IDLE and GRANT.
- Winner selection (combinational, from req_i):
  - PRIO_MODE=0: first set bit scanning ptr, ptr+1, ... NUM_PORTS-1, 0, ... ptr-1.
  - PRIO_MODE=1: lowest set index; ptr is ignored.
- IDLE:
  - If req_i is nonzero, the winner's grant appears on the next edge and the state becomes GRANT. Latency is 1 cycle.
  - If req_i is zero, stay in IDLE.
  - done_i is ignored in IDLE.
- GRANT:
  - gnt_o, gnt_idx_o and gnt_valid_o are stable.
  - The hold counter loads 0 on every new grant and increments each GRANT cycle.
- Release condition, evaluated each GRANT cycle:
  - done_i=1, or
  - req_i[owner]=0, or
  - MAX_HOLD!=0 and hold counter == MAX_HOLD-1.
  - A grant therefore lasts at most MAX_HOLD cycles.
- On the release cycle:
  - ptr <= owner+1, wrapping NUM_PORTS-1 to 0. ptr is updated in both modes but used only in mode 0.
  - Re-arbitrate in the same cycle over req_i, using the updated pointer value.
  - If there is a winner, it is granted on the next edge with no idle gap.
  - The released owner may win again if it is the only requester. In that case gnt_o stays the same and the hold counter restarts at 0.
  - If there is no winner, go to IDLE and drive gnt_o=0 and gnt_valid_o=0 on the next edge.
- Simultaneous release causes (done_i with owner req drop, or timeout) are treated as one release.
- Requests from non-owners during GRANT are never granted before the release.
- gnt_o is always one-hot or all-zero; it is never multi-hot.
- Reset mid-grant: outputs are zero on the next edge and ptr returns to 0.

Decomposition:
- Package arbiter_pkg:
  - state enum arb_state_e {ARB_IDLE, ARB_GRANT}.
  - Mode constants ARB_MODE_RR=0, ARB_MODE_FIXED=1.
  - Function onehot_to_idx.
- Sub-module arbiter_rr_pick (combinational):
  - Inputs: req, ptr, mode.
  - Outputs: one-hot winner and an any-valid flag.
  - Implementation: masked-request / double-width rotate.
- The top level holds the FSM, ptr, hold counter and output registers.

Test Plan:
All scenarios use NUM_PORTS=4 and MAX_HOLD=4 unless stated.
1. Reset: rst_i=1 for 3 cycles with req_i=4'b1111 -> gnt_o=0, gnt_valid_o=0, gnt_idx_o=0 throughout. After release of reset, gnt_o=4'b0001 one cycle later.
2. Round-robin with done: req_i=4'b1010 from IDLE -> next cycle gnt_o=4'b0010, idx=1. Pulse done_i -> next cycle gnt_o=4'b1000, idx=3. After the next done_i -> gnt_o=4'b0010 (ptr has wrapped to 0).
3. Hold timeout: req_i=4'b0101 held, done_i=0 -> gnt_o=4'b0001 for exactly 4 cycles, then 4'b0100 for 4 cycles, then 4'b0001, with no zero cycles between grants.
4. Sole requester and owner drop: req_i=4'b0100 steady -> gnt_o=4'b0100 continuously, with the counter restarting every 4 cycles. Then drop req_i to 0 -> gnt_o=0 and gnt_valid_o=0 next cycle; the FSM is in IDLE.
5. Fixed mode (PRIO_MODE=1, MAX_HOLD=0): req_i=4'b1111 with done_i pulsed on every grant -> gnt_o=4'b0001 every time. Then req_i=4'b1100 -> 4'b0100.
6. Reset mid-grant: port 2 granted, rst_i=1 for 1 cycle -> gnt_o=0 next edge. Then req_i=4'b1001 -> gnt_o=4'b0001 (ptr reset to 0), not 4'b1000.
